// File: rtl/interrupt_controller_pkg.sv
// Shared types and defaults for the interrupt front end: FSM state encoding
// and the parameter defaults used by the top and the pin synchroniser.
package interrupt_controller_pkg;

   localparam int unsigned DEF_PC_WIDTH    = 32;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_VECTOR_ADDR = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_CALL   = 3'd2,
      ST_SAVE   = 3'd3,
      ST_VECTOR = 3'd4,
      ST_ISR    = 3'd5
   } irq_state_e;

   function automatic logic state_is_busy(irq_state_e s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/interrupt_controller_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge
// detector; reusable for any external level input.
module sync_edge_detect
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   dly_q;
   logic                   dly_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
      dly_d  = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   // Only the 0->1 transition of the synchronised level counts as a request.
   assign o_rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: latches a pending request from the external pin,
// waits for a safe point, then steps through call, return-PC save and vector fetch.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned VECTOR_ADDR = DEF_VECTOR_ADDR
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_int_req,
   input  logic                i_stall_interrupt,
   input  logic                i_branch_decision,
   input  logic                i_rti,
   input  logic [PC_WIDTH-1:0] i_pc_d,
   output logic                o_interrupt_call,
   output logic                o_save_valid,
   output logic [PC_WIDTH-1:0] o_save_pc,
   output logic                o_vector_fetch,
   output logic [PC_WIDTH-1:0] o_vector_addr,
   output logic                o_in_isr,
   output logic                o_busy
);

   logic rise;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_detect (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_int_req),
      .o_rise  (rise)
   );

   irq_state_e          state_q;
   irq_state_e          state_d;
   logic                pending_q;
   logic                pending_d;
   logic [PC_WIDTH-1:0] save_pc_q;
   logic [PC_WIDTH-1:0] save_pc_d;
   logic                call_q;
   logic                save_valid_q;
   logic                vector_fetch_q;
   logic                in_isr_q;
   logic                busy_q;
   logic                safe_point;

   assign safe_point = ~i_stall_interrupt & ~i_branch_decision;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      save_pc_d = save_pc_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (safe_point) begin
               state_d   = ST_CALL;
               save_pc_d = i_pc_d;
               pending_d = 1'b0;
            end
         end
         ST_CALL:   state_d = ST_SAVE;
         ST_SAVE:   state_d = ST_VECTOR;
         ST_VECTOR: state_d = ST_ISR;
         ST_ISR: begin
            if (i_rti) begin
               state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase

      // A fresh edge always wins, including the cycle that consumes the old one.
      if (rise) begin
         pending_d = 1'b1;
      end
   end

   // Strobes are registered from the next state so they are clean flop outputs
   // that line up exactly with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= ST_IDLE;
         pending_q      <= 1'b0;
         save_pc_q      <= '0;
         call_q         <= 1'b0;
         save_valid_q   <= 1'b0;
         vector_fetch_q <= 1'b0;
         in_isr_q       <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         save_pc_q      <= save_pc_d;
         call_q         <= (state_d == ST_CALL);
         save_valid_q   <= (state_d == ST_SAVE);
         vector_fetch_q <= (state_d == ST_VECTOR);
         in_isr_q       <= (state_d == ST_ISR);
         busy_q         <= state_is_busy(state_d);
      end
   end

   assign o_interrupt_call = call_q;
   assign o_save_valid     = save_valid_q;
   assign o_save_pc        = save_pc_q;
   assign o_vector_fetch   = vector_fetch_q;
   assign o_vector_addr    = PC_WIDTH'(VECTOR_ADDR);
   assign o_in_isr         = in_isr_q;
   assign o_busy           = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: strobe events are predicted into a
// queue with their cycle and checked as the DUT emits them.
module tb_interrupt_controller;

   localparam int unsigned PCW = 32;
   localparam logic [31:0] VEC = 32'h0000_0100;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           int_req;
   logic           stall;
   logic           branch;
   logic           rti;
   logic [PCW-1:0] pc_d;
   logic           call;
   logic           save_valid;
   logic [PCW-1:0] save_pc;
   logic           vec_fetch;
   logic [PCW-1:0] vec_addr;
   logic           in_isr;
   logic           busy;

   int          cyc = 0;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          c0;
   logic [49:0] exp_q[$];

   always #5 clk = ~clk;

   interrupt_controller #(
      .PC_WIDTH    (PCW),
      .SYNC_STAGES (2),
      .VECTOR_ADDR (VEC)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_int_req         (int_req),
      .i_stall_interrupt (stall),
      .i_branch_decision (branch),
      .i_rti             (rti),
      .i_pc_d            (pc_d),
      .o_interrupt_call  (call),
      .o_save_valid      (save_valid),
      .o_save_pc         (save_pc),
      .o_vector_fetch    (vec_fetch),
      .o_vector_addr     (vec_addr),
      .o_in_isr          (in_isr),
      .o_busy            (busy)
   );

   // Event word: {kind, pc, cycle}; kind 1=call, 2=save, 3=vector.
   function automatic logic [49:0] ev(int kind, logic [31:0] pc, int c);
      logic [1:0]  k;
      logic [15:0] cc;
      k  = kind[1:0];
      cc = c[15:0];
      return {k, pc, cc};
   endfunction

   task automatic push(int kind, logic [31:0] pc, int c);
      exp_q.push_back(ev(kind, pc, c));
   endtask

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_strobe(int kind, logic [31:0] pc, string tag);
      logic [49:0] got;
      logic [49:0] e;
      got = ev(kind, pc, cyc);
      e   = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
      tests_run++;
      assert (got === e) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, e, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (call)       check_strobe(1, 32'h0, "call_event");
      if (save_valid) check_strobe(2, save_pc, "save_event");
      if (vec_fetch)  check_strobe(3, 32'h0, "vector_event");
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      int_req = 1'b0;
      stall   = 1'b0;
      branch  = 1'b0;
      rti     = 1'b0;
      pc_d    = '0;

      // Reset: pin activity while held in reset must not leak through.
      ticks(1);
      int_req = 1'b1;
      ticks(3);
      int_req = 1'b0;
      ticks(1);
      chk("rst_call", call, 0);
      chk("rst_save_valid", save_valid, 0);
      chk("rst_save_pc", save_pc, 0);
      chk("rst_vector_fetch", vec_fetch, 0);
      chk("rst_in_isr", in_isr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_vector_addr", vec_addr, VEC);
      rst_n = 1'b1;
      ticks(10);
      chk("post_rst_idle", busy, 0);

      // Basic entry latency.
      pc_d    = 32'h0000_0040;
      int_req = 1'b1;
      c0      = cyc;
      push(1, 32'h0, c0 + 5);
      push(2, 32'h40, c0 + 6);
      push(3, 32'h0, c0 + 7);
      ticks(2);
      int_req = 1'b0;
      ticks(1);
      chk("basic_idle_at_e3", busy, 0);
      ticks(1);
      chk("basic_wait_at_e4", busy, 1);
      ticks(1);
      chk("basic_call_at_e5", call, 1);
      pc_d = 32'h0000_1234;
      ticks(3);
      chk("basic_in_isr_e8", in_isr, 1);
      ticks(3);
      chk("basic_in_isr_hold", in_isr, 1);
      chk("basic_save_pc_hold", save_pc, 32'h40);
      rti = 1'b1;
      ticks(1);
      rti = 1'b0;
      chk("basic_rti_in_isr", in_isr, 0);
      chk("basic_rti_busy", busy, 0);

      // Stall for three WAIT cycles, then one branch cycle.
      stall   = 1'b1;
      pc_d    = 32'h0000_0070;
      int_req = 1'b1;
      c0      = cyc;
      ticks(2);
      int_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pc_d = 32'h0000_0070 + 32'(i);
      end
      chk("stall_wait_busy", busy, 1);
      chk("stall_no_isr", in_isr, 0);
      stall  = 1'b0;
      branch = 1'b1;
      pc_d   = 32'h0000_0080;
      ticks(1);
      chk("branch_wait_busy", busy, 1);
      branch = 1'b0;
      pc_d   = 32'h0000_0088;
      push(1, 32'h0, c0 + 9);
      push(2, 32'h88, c0 + 10);
      push(3, 32'h0, c0 + 11);
      ticks(1);
      stall  = 1'b1;
      branch = 1'b1;
      ticks(3);
      chk("stall_ignored_isr", in_isr, 1);
      stall  = 1'b0;
      branch = 1'b0;

      // Coalescing: three pulses during the ISR yield one further entry.
      for (int p = 0; p < 3; p++) begin
         int_req = 1'b1;
         ticks(3);
         int_req = 1'b0;
         ticks(3);
      end
      ticks(3);
      chk("no_nesting_in_isr", in_isr, 1);
      pc_d = 32'h0000_0200;
      rti  = 1'b1;
      c0   = cyc;
      push(1, 32'h0, c0 + 3);
      push(2, 32'h200, c0 + 4);
      push(3, 32'h0, c0 + 5);
      ticks(1);
      rti = 1'b0;
      chk("coalesce_idle", busy, 0);
      ticks(1);
      chk("coalesce_wait", busy, 1);
      ticks(4);
      chk("coalesce_isr", in_isr, 1);
      rti = 1'b1;
      ticks(1);
      rti = 1'b0;
      ticks(15);
      chk("coalesce_single", busy, 0);
      rti = 1'b1;
      ticks(1);
      rti = 1'b0;
      ticks(10);
      chk("rti_idle_busy", busy, 0);
      chk("rti_idle_isr", in_isr, 0);

      // Reset during SAVE with a second rise already pending.
      pc_d    = 32'h0000_0300;
      int_req = 1'b1;
      c0      = cyc;
      push(1, 32'h0, c0 + 5);
      push(2, 32'h300, c0 + 6);
      ticks(2);
      int_req = 1'b0;
      ticks(1);
      int_req = 1'b1;
      ticks(3);
      chk("mid_save_valid", save_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_save_drop", save_valid, 0);
      chk("mid_rst_busy_drop", busy, 0);
      int_req = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      ticks(12);
      chk("mid_rst_pending_lost", busy, 0);
      chk("mid_rst_save_pc", save_pc, 0);

      // Held level: exactly one entry.
      pc_d    = 32'h0000_0400;
      int_req = 1'b1;
      c0      = cyc;
      push(1, 32'h0, c0 + 5);
      push(2, 32'h400, c0 + 6);
      push(3, 32'h0, c0 + 7);
      ticks(8);
      chk("held_in_isr", in_isr, 1);
      ticks(7);
      rti = 1'b1;
      ticks(1);
      rti = 1'b0;
      ticks(34);
      chk("held_no_retrigger", busy, 0);
      int_req = 1'b0;
      ticks(10);
      chk("held_idle_end", busy, 0);

      chk("events_outstanding", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
